// File: rtl/nibble_add_seq_if.sv
// Bus bundle for nibble_add_seq: requester handshake, operands and result,
// plus the pins to and from the shared 4-bit adder.
// Ovf is present only when NIBBLE_ADD_SEQ_OVF_EN is defined.
interface nibble_add_seq_if #(
    parameter int unsigned NIBBLES = 4
);
    localparam int unsigned W = 4 * NIBBLES;

    // Requester side
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic         Ovf;
`endif

    // Shared adder side
    logic [3:0]   AdA;
    logic [3:0]   AdB;
    logic         AdCin;
    logic [3:0]   AdS;
    logic         AdCout;

    // Environment view: the requester plus the shared adder
    modport master (
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        input  Ovf,
`endif
        output start, sub, A, B, AdS, AdCout,
        input  ready, busy, done, Sum, Cout, AdA, AdB, AdCin
    );

    // Sequencer view
    modport slave (
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        output Ovf,
`endif
        input  start, sub, A, B, AdS, AdCout,
        output ready, busy, done, Sum, Cout, AdA, AdB, AdCin
    );
endinterface

// File: rtl/nibble_add_seq.sv
// Nibble-serial add/subtract sequencer driving one shared 4-bit adder.
// One nibble is processed per clock; subtract uses A + ~B + 1.
// Optional signed-overflow output enabled by NIBBLE_ADD_SEQ_OVF_EN.
module nibble_add_seq #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    nibble_add_seq_if.slave   bus
);
    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [W-1:0]     opa_q,   opa_d;
    logic [W-1:0]     opb_q,   opb_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q,   sum_d;
    logic             cout_q,  cout_d;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    logic             last_nib;
    logic [IDX_W+1:0] nib_base;

    assign last_nib = (idx_q == LAST_IDX);
    assign nib_base = {idx_q, 2'b00};

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state logic: start only honoured in IDLE, DONE always lasts one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: operand capture on start, one nibble written per RUN cycle
    always_comb begin
        idx_d   = idx_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    opa_d   = bus.A;
                    opb_d   = bus.sub ? ~bus.B : bus.B;
                    carry_d = bus.sub;
                    idx_d   = '0;
                end
            end
            RUN: begin
                sum_d[nib_base +: 4] = bus.AdS;
                carry_d              = bus.AdCout;
                if (last_nib) begin
                    // idx parks on the last nibble rather than wrapping
                    cout_d = bus.AdCout;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
                    ovf_d  = (opa_q[W-1] ^ bus.AdS[3]) & (opb_q[W-1] ^ bus.AdS[3]);
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Outputs: status decoded from state, adder pins quiet outside RUN
    always_comb begin
        bus.ready = (state_q == IDLE);
        bus.busy  = (state_q == RUN);
        bus.done  = (state_q == DONE);
        bus.Sum   = sum_q;
        bus.Cout  = cout_q;
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        bus.Ovf   = ovf_q;
`endif
        bus.AdA   = '0;
        bus.AdB   = '0;
        bus.AdCin = 1'b0;
        if (state_q == RUN) begin
            bus.AdA   = opa_q[nib_base +: 4];
            bus.AdB   = opb_q[nib_base +: 4];
            bus.AdCin = carry_q;
        end
    end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4); models the shared adder
// and predicts results with plain arithmetic on the full-width operands.
module tb_nibble_add_seq;
    localparam int unsigned NIB = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    nibble_add_seq_if #(.NIBBLES(NIB)) bus ();

    nibble_add_seq #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared 4-bit adder
    assign {bus.AdCout, bus.AdS} = 5'(bus.AdA) + 5'(bus.AdB) + 5'(bus.AdCin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation, checked cycle by cycle; poke=1 also pulses start
    // during RUN and in the DONE cycle, which must be ignored.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s, input bit poke);
        logic [15:0] bb;
        logic [15:0] e_sum;
        logic        e_cout;
        int          sa, sb, sr;
        logic        e_ovf;
        int unsigned mask, cin;

        bb     = s ? ~b : b;
        e_sum  = s ? (a - b) : (a + b);
        e_cout = s ? (a >= b) : ((32'(a) + 32'(b)) > 32'hFFFF);
        sa     = int'($signed(a));
        sb     = int'($signed(b));
        sr     = s ? (sa - sb) : (sa + sb);
        e_ovf  = (sr > 32767) || (sr < -32768);

        chk("ready_idle", 32'(bus.ready), 1);
        bus.A = a; bus.B = b; bus.sub = s; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A = 16'($urandom); bus.B = 16'($urandom); bus.sub = 1'($urandom);

        for (int i = 0; i < int'(NIB); i++) begin
            mask = (32'd1 << (4 * i)) - 1;
            cin  = (i == 0) ? 32'(s) : (((32'(a) & mask) + (32'(bb) & mask) + 32'(s)) >> (4 * i)) & 1;
            chk("busy_run",  32'(bus.busy),  1);
            chk("done_run",  32'(bus.done),  0);
            chk("ready_run", 32'(bus.ready), 0);
            chk("AdA",       32'(bus.AdA),   32'((a  >> (4 * i)) & 16'hF));
            chk("AdB",       32'(bus.AdB),   32'((bb >> (4 * i)) & 16'hF));
            chk("AdCin",     32'(bus.AdCin), cin);
            if (poke && i == 1) begin
                bus.start = 1'b1; bus.A = 16'h1111; bus.B = 16'h1111;
            end
            if (poke && i == 2) bus.start = 1'b0;
            @(negedge clk);
        end

        chk("done_pulse", 32'(bus.done),  1);
        chk("busy_done",  32'(bus.busy),  0);
        chk("ready_done", 32'(bus.ready), 0);
        chk("sum",        32'(bus.Sum),   32'(e_sum));
        chk("cout",       32'(bus.Cout),  32'(e_cout));
        chk("AdA_idle",   32'(bus.AdA),   0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        chk("ovf",        32'(bus.Ovf),   32'(e_ovf));
`else
        if (e_ovf) begin end
`endif
        if (poke) begin
            bus.start = 1'b1; bus.A = 16'h1111; bus.B = 16'h1111;
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("ready_after", 32'(bus.ready), 1);
        chk("done_after",  32'(bus.done),  0);
        chk("sum_held",    32'(bus.Sum),   32'(e_sum));
        chk("cout_held",   32'(bus.Cout),  32'(e_cout));
        if (poke) begin
            @(negedge clk);
            chk("busy_ignored",  32'(bus.busy),  0);
            chk("done_ignored",  32'(bus.done),  0);
            chk("sum_ignored",   32'(bus.Sum),   32'(e_sum));
        end
    endtask

    initial begin
        rst_n = 1'b0; bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0;
        #1;
        chk("rst_ready", 32'(bus.ready), 1);
        chk("rst_busy",  32'(bus.busy),  0);
        chk("rst_done",  32'(bus.done),  0);
        chk("rst_sum",   32'(bus.Sum),   0);
        chk("rst_cout",  32'(bus.Cout),  0);
        chk("rst_AdA",   32'(bus.AdA),   0);
`ifdef NIBBLE_ADD_SEQ_OVF_EN
        chk("rst_ovf",   32'(bus.Ovf),   0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, first one with ignored start pulses
        do_op(16'h1234, 16'h4321, 1'b0, 1'b1);
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
        do_op(16'h0000, 16'h8000, 1'b1, 1'b0);

        // Reset in the second RUN cycle aborts the operation
        chk("ready_pre_abort", 32'(bus.ready), 1);
        bus.A = 16'h00FF; bus.B = 16'h0001; bus.sub = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("busy_pre_abort", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(bus.ready), 1);
        chk("abort_busy",  32'(bus.busy),  0);
        chk("abort_done",  32'(bus.done),  0);
        chk("abort_sum",   32'(bus.Sum),   0);
        chk("abort_cout",  32'(bus.Cout),  0);
        chk("abort_AdCin", 32'(bus.AdCin), 0);
        @(negedge clk);
        chk("abort_no_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_no_done2", 32'(bus.done), 0);
        do_op(16'h0001, 16'h0001, 1'b0, 1'b0);

        // Random operations
        for (int k = 0; k < 24; k++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule
